midi_spi_tx_router: RTL and testbench
=====================================

// Module: midi_spi_tx_router
// PURPOSE
//  Parametrised SPI-to-MIDI output path. Bytes written by the MCU over the SPI
//  slave port are buffered in a FIFO, serialised as 31250-baud MIDI/UART frames
//  and fanned out to NUM_OUT MIDI outputs under a per-output enable mask.
//  Replaces the raw mosi-to-midi_out pass-through with framed, buffered TX.
// PARAMETERS
//  CLKS_PER_BIT  384  clk cycles per MIDI bit (12 MHz / 31250 baud)
//  FIFO_DEPTH    16   FIFO entries; power of two, >= 2
//  NUM_OUT       4    number of MIDI output lines
//  SYNC_STAGES   2    synchroniser flops on spi_clk/spi_mosi/spi_ss, >= 2
// PORTS
//  clk         in   1                  system clock
//  rst         in   1                  asynchronous reset, active-high
//  spi_clk     in   1                  SPI clock (mode 0), async to clk, <= clk/8
//  spi_mosi    in   1                  SPI data in, MSB first
//  spi_ss      in   1                  SPI select, active-low
//  spi_miso    out  1                  flow control: registered copy of fifo_full
//  out_en      in   NUM_OUT            per-output enable mask
//  midi_out    out  NUM_OUT            MIDI serial outputs, idle high
//  fifo_level  out  $clog2(DEPTH)+1    entries in FIFO, 0..FIFO_DEPTH
//  fifo_empty  out  1                  fifo_level == 0
//  fifo_full   out  1                  fifo_level == FIFO_DEPTH
//  overflow    out  1                  sticky: a received byte was dropped
// BEHAVIOUR
//  Reset: midi_out all 1, spi_miso 0, FIFO empty (level 0, empty 1, full 0),
//   overflow 0, SPI bit count 0, TX FSM IDLE. Reset is async, so all outputs
//   take reset values immediately, also mid-frame.
//  SPI RX: spi_* pass SYNC_STAGES flops; rising edge of synced spi_clk while
//   synced spi_ss low shifts mosi in. On 8th bit, byte is pushed the next cycle.
//   synced spi_ss high clears bit count and discards partial byte.
//  FIFO: push accepted if !full, or if full and a pop occurs the same cycle.
//   Otherwise byte dropped, overflow set (cleared only by rst). Simultaneous
//   push+pop leaves level unchanged. Pointers wrap modulo FIFO_DEPTH.
//  TX FSM: IDLE -> START -> DATA -> STOP -> (IDLE | START).
//   IDLE: if !fifo_empty, pop head into shift reg, latch out_en, go START.
//   START: line 0 for CLKS_PER_BIT cycles. DATA: 8 bits LSB first, each
//   CLKS_PER_BIT cycles. STOP: line 1 for CLKS_PER_BIT cycles; at end, if
//   !fifo_empty pop and go START directly (no idle gap), else IDLE.
//   Frame = 10*CLKS_PER_BIT cycles.
//  Latency: push in cycle N -> fifo_empty low N+1 -> pop N+1 -> midi_out start
//   bit (0) from N+2.
//  Output: midi_out[i] registered = latched_en[i] ? tx_line : 1. out_en is
//   latched only at pop, so a mask change never truncates a frame.
// TESTING
//  1 Assert rst mid-operation -> midi_out=all 1, fifo_level=0, empty=1, overflow=0.
//  2 out_en=4'b0101, SPI 0x90 -> outs 0,2: 0,0,0,0,0,1,0,0,1,1 at 384 clk/bit;
//    outs 1,3 stay 1.
//  3 SPI 0x90,0x3C,0x7F back-to-back -> 3 contiguous frames, 30*384 cycles, no gap.
//  4 Fast SPI, 18 bytes, DEPTH=16 -> byte 1 in TX, 16 queued, byte 18 dropped;
//    overflow=1, full=1, spi_miso=1; exactly 17 frames out, level ends at 0.
//  5 spi_ss high after 5 bits, then full byte 0x55 -> no push for partial;
//    one frame of 0x55 only.
//  6 Change out_en 4'b1111->4'b0001 mid-frame -> current frame completes on all
//    four outputs; next frame on output 0 only.

Source files
------------

// File: rtl/midi_spi_tx_router.sv
// midi_spi_tx_router
//  Buffered SPI-to-MIDI transmit path. Bytes shifted in over an SPI mode-0
//  slave port are queued in a FIFO and sent as 8N1 UART frames at
//  CLKS_PER_BIT clocks per bit. Each frame is fanned out to the MIDI outputs
//  selected by the out_en mask, which is sampled when the byte is popped.
// Ports
//  clk, rst            system clock, asynchronous active-high reset
//  spi_clk/mosi/ss     SPI slave inputs (async to clk), ss active-low
//  spi_miso            flow control, registered copy of fifo_full
//  out_en              per-output enable mask
//  midi_out            MIDI serial outputs, idle high
//  fifo_level/empty/full  FIFO occupancy status
//  overflow            sticky: a received byte was dropped
module midi_spi_tx_router #(
    parameter int unsigned CLKS_PER_BIT = 384,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned NUM_OUT      = 4,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          spi_clk,
    input  logic                          spi_mosi,
    input  logic                          spi_ss,
    output logic                          spi_miso,
    input  logic [NUM_OUT-1:0]            out_en,
    output logic [NUM_OUT-1:0]            midi_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic                          overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Synchronisers and SPI receive state
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic [6:0]             rx_shift_q,  rx_shift_d;
    logic [2:0]             rx_cnt_q,    rx_cnt_d;
    logic                   rx_push_q,   rx_push_d;
    logic [7:0]             rx_byte_q,   rx_byte_d;

    // FIFO state
    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q,  level_d;
    logic                   empty_q,  empty_d;
    logic                   full_q,   full_d;
    logic                   overflow_q, overflow_d;
    logic                   miso_q,   miso_d;

    // Transmitter state
    tx_state_t              state_q,  state_d;
    logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic [NUM_OUT-1:0]     en_q,     en_d;
    logic [NUM_OUT-1:0]     midi_out_q, midi_out_d;

    logic sclk_s, mosi_s, ss_s, sclk_rise;
    logic push_ok, tx_pop, line_d, bit_last;
    logic [7:0] head;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign head      = mem_q[rd_ptr_q];
    assign bit_last  = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // SPI receiver: sample on synced rising edge, push one cycle after 8th bit
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi_ss};
        sclk_prev_d = sclk_s;
        rx_shift_d  = rx_shift_q;
        rx_cnt_d    = rx_cnt_q;
        rx_push_d   = 1'b0;
        rx_byte_d   = rx_byte_q;
        if (ss_s) begin
            rx_cnt_d = 3'd0;
        end else if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[5:0], mosi_s};
            rx_cnt_d   = rx_cnt_q + 3'd1;
            if (rx_cnt_q == 3'd7) begin
                rx_push_d = 1'b1;
                rx_byte_d = {rx_shift_q, mosi_s};
            end
        end
    end

    // FIFO bookkeeping; a full FIFO still accepts a push when the TX pops
    always_comb begin
        push_ok    = rx_push_q & (~full_q | tx_pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = tx_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d    = level_q;
        if (push_ok && !tx_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push_ok && tx_pop) begin
            level_d = level_q - LVL_W'(1);
        end
        empty_d    = (level_d == LVL_W'(0));
        full_d     = (level_d == LVL_W'(FIFO_DEPTH));
        overflow_d = overflow_q | (rx_push_q & ~push_ok);
        miso_d     = full_q;
    end

    // Frame transmitter; output mask is captured with each popped byte
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        en_d       = en_q;
        tx_pop     = 1'b0;
        line_d     = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (!empty_q) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = head;
                    en_d       = out_en;
                    clk_cnt_d  = '0;
                    state_d    = ST_START;
                    line_d     = 1'b0;
                end
            end
            ST_START: begin
                line_d = 1'b0;
                if (bit_last) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = 3'd0;
                    state_d   = ST_DATA;
                    line_d    = tx_shift_q[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                line_d = tx_shift_q[0];
                if (bit_last) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                        line_d  = 1'b1;
                    end else begin
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        line_d     = tx_shift_q[1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                line_d = 1'b1;
                if (bit_last) begin
                    clk_cnt_d = '0;
                    // Chain straight into the next start bit when data waits
                    if (!empty_q) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = head;
                        en_d       = out_en;
                        state_d    = ST_START;
                        line_d     = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        midi_out_d = ~en_d | {NUM_OUT{line_d}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            rx_shift_q  <= '0;
            rx_cnt_q    <= 3'd0;
            rx_push_q   <= 1'b0;
            rx_byte_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            miso_q      <= 1'b0;
            state_q     <= ST_IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= 3'd0;
            tx_shift_q  <= '0;
            en_q        <= '0;
            midi_out_q  <= '1;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_sync_q   <= ss_sync_d;
            sclk_prev_q <= sclk_prev_d;
            rx_shift_q  <= rx_shift_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_push_q   <= rx_push_d;
            rx_byte_q   <= rx_byte_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            miso_q      <= miso_d;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            en_q        <= en_d;
            midi_out_q  <= midi_out_d;
        end
    end

    // FIFO storage needs no reset; level and pointers gate its use
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= rx_byte_q;
        end
    end

    assign spi_miso   = miso_q;
    assign midi_out   = midi_out_q;
    assign fifo_level = level_q;
    assign fifo_empty = empty_q;
    assign fifo_full  = full_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_midi_spi_tx_router.sv
// Bench for midi_spi_tx_router: directed scenarios plus random bursts,
// with received MIDI frames decoded per line and matched against a queue
// of bytes the bench expects to see.
module tb_midi_spi_tx_router;

    localparam int CPB   = 128;
    localparam int DEPTH = 16;
    localparam int NOUT  = 4;
    localparam int FRAME = 10 * CPB;

    logic            clk = 1'b0;
    logic            rst;
    logic            spi_clk, spi_mosi, spi_ss, spi_miso;
    logic [NOUT-1:0] out_en, midi_out;
    logic [4:0]      fifo_level;
    logic            fifo_empty, fifo_full, overflow;

    midi_spi_tx_router #(
        .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .NUM_OUT(NOUT), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_ss(spi_ss), .spi_miso(spi_miso), .out_en(out_en),
        .midi_out(midi_out), .fifo_level(fifo_level), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int         start_times[$];
    int         mon_frames = 0;
    logic       mon_busy   = 1'b0;
    int         mon_t      = 0;
    logic [9:0] mon_bits [NOUT];
    logic [NOUT-1:0] mon_mask = '0;
    logic [NOUT-1:0] en_last  = '1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Frame decoder: start on any low line, sample each bit at its centre
    always @(negedge clk) begin
        if (rst) begin
            mon_busy = 1'b0;
        end else begin
            if (!mon_busy && midi_out !== 4'hF) begin
                mon_busy = 1'b1;
                mon_t    = 0;
                mon_mask = en_last;
                start_times.push_back(cyc);
            end
            if (mon_busy) begin
                if (mon_t % CPB == CPB / 2) begin
                    for (int i = 0; i < NOUT; i++) mon_bits[i][mon_t / CPB] = midi_out[i];
                    if (mon_t / CPB == 9) begin
                        logic [39:0] got, exp;
                        logic [7:0]  b;
                        mon_busy = 1'b0;
                        mon_frames++;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_frame", 64'd1, 64'd0);
                        end else begin
                            b = exp_q.pop_front();
                            for (int i = 0; i < NOUT; i++) begin
                                got[i*10 +: 10] = mon_bits[i];
                                exp[i*10 +: 10] = mon_mask[i] ? {1'b1, b, 1'b0} : 10'h3FF;
                            end
                            chk("frame", 64'(got), 64'(exp));
                        end
                    end
                end
                mon_t++;
            end
        end
        en_last = out_en;
    end

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            repeat (4) @(negedge clk);
            spi_clk = 1'b1;
            repeat (4) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    task automatic spi_sel();
        spi_ss = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_desel();
        repeat (4) @(negedge clk);
        spi_ss = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic expect_out);
        spi_bits(b, 8);
        if (expect_out) exp_q.push_back(b);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (mon_frames < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("frame_timeout", 64'(mon_frames >= target), 64'd1);
    endtask

    task automatic wait_line_active(input int budget);
        int n = 0;
        while (midi_out === 4'hF && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("start_timeout", 64'(midi_out !== 4'hF), 64'd1);
    endtask

    initial begin
        int base, sidx;
        logic [7:0] rb;
        int nb;

        rst = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_ss = 1'b1; out_en = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_midi", 64'(midi_out), 64'hF);
        chk("rst_miso", 64'(spi_miso), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_empty", 64'(fifo_empty), 64'd1);
        chk("rst_full", 64'(fifo_full), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte on outputs 0 and 2, with push-to-start latency
        out_en = 4'b0101;
        base = mon_frames;
        spi_sel();
        spi_bits(8'h90, 8);
        exp_q.push_back(8'h90);
        begin
            int n = 0;
            while (fifo_level !== 5'd1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("lat_level1", 64'(fifo_level), 64'd1);
            chk("lat_idle", 64'(midi_out), 64'hF);
            @(negedge clk);
            chk("lat_start", 64'(midi_out), 64'b1010);
            chk("lat_popped", 64'(fifo_empty), 64'd1);
        end
        spi_desel();
        wait_frames(base + 1, FRAME + 500);

        // Three back-to-back frames with no idle gap
        out_en = 4'hF;
        base = mon_frames;
        sidx = start_times.size();
        spi_sel();
        send(8'h90, 1'b1);
        send(8'h3C, 1'b1);
        send(8'h7F, 1'b1);
        spi_desel();
        wait_frames(base + 3, 3 * FRAME + 500);
        if (start_times.size() >= sidx + 3) begin
            chk("gap_1_2", 64'(start_times[sidx+1] - start_times[sidx]), 64'(FRAME));
            chk("gap_2_3", 64'(start_times[sidx+2] - start_times[sidx+1]), 64'(FRAME));
        end else begin
            chk("start_count", 64'(start_times.size() - sidx), 64'd3);
        end

        // Overflow: 18 fast bytes, one in flight, 16 queued, last dropped
        base = mon_frames;
        spi_sel();
        for (int i = 0; i < 18; i++) send(8'(8'h20 + i), i < 17);
        spi_desel();
        chk("ovf_level", 64'(fifo_level), 64'd16);
        chk("ovf_full", 64'(fifo_full), 64'd1);
        chk("ovf_miso", 64'(spi_miso), 64'd1);
        chk("ovf_flag", 64'(overflow), 64'd1);
        wait_frames(base + 17, 17 * FRAME + 1000);
        repeat (2 * FRAME) @(negedge clk);
        chk("ovf_frames", 64'(mon_frames - base), 64'd17);
        chk("ovf_drained", 64'(fifo_level), 64'd0);
        chk("ovf_empty", 64'(fifo_empty), 64'd1);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Asynchronous reset in the middle of a frame
        spi_sel();
        send(8'hA5, 1'b1);
        spi_desel();
        wait_line_active(300);
        repeat (3 * CPB) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_midi", 64'(midi_out), 64'hF);
        chk("arst_level", 64'(fifo_level), 64'd0);
        chk("arst_empty", 64'(fifo_empty), 64'd1);
        chk("arst_ovf", 64'(overflow), 64'd0);
        chk("arst_miso", 64'(spi_miso), 64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * FRAME) @(negedge clk);
        chk("arst_quiet", 64'(midi_out), 64'hF);

        // Partial byte discarded by deselect, then a clean 0x55
        base = mon_frames;
        spi_sel();
        spi_bits(8'hFF, 5);
        spi_desel();
        repeat (30) @(negedge clk);
        chk("part_level", 64'(fifo_level), 64'd0);
        chk("part_line", 64'(midi_out), 64'hF);
        spi_sel();
        send(8'h55, 1'b1);
        spi_desel();
        wait_frames(base + 1, FRAME + 500);
        repeat (FRAME) @(negedge clk);
        chk("part_frames", 64'(mon_frames - base), 64'd1);

        // Mask change mid-frame applies only to the following frame
        out_en = 4'hF;
        base = mon_frames;
        spi_sel();
        send(8'hA1, 1'b1);
        send(8'h5E, 1'b1);
        spi_desel();
        wait_line_active(300);
        repeat (5 * CPB) @(negedge clk);
        out_en = 4'b0001;
        wait_frames(base + 2, 2 * FRAME + 500);

        // Random bursts with random nonzero masks
        for (int r = 0; r < 4; r++) begin
            out_en = 4'($urandom_range(1, 15));
            nb = $urandom_range(1, 3);
            base = mon_frames;
            spi_sel();
            for (int k = 0; k < nb; k++) begin
                rb = 8'($urandom);
                send(rb, 1'b1);
            end
            spi_desel();
            wait_frames(base + nb, nb * FRAME + 500);
            repeat ($urandom_range(10, 200)) @(negedge clk);
        end

        repeat (CPB) @(negedge clk);
        chk("end_queue", 64'(exp_q.size()), 64'd0);
        chk("end_empty", 64'(fifo_empty), 64'd1);
        chk("end_idle", 64'(midi_out), 64'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
